// File: rtl/truth_table_sweep_pkg.sv
// Shared definitions for the truth-table sweep stage: FSM encodings,
// vector count, default dwell and a popcount helper for the optional checker.
package truth_table_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    localparam int N_VEC         = 16;
    localparam int DEFAULT_DWELL = 20;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_sweep_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and raises tc on the last
// count, which the sweep uses as its sample strobe.
module truth_table_sweep_dwell_counter #(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(DWELL + 1);

    logic [CW-1:0] count;

    // With DWELL = 1 the count stays at zero and tc follows en directly.
    assign tc = en && (count == CW'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Drives all 16 {a,b,c,d} combinations with a fixed dwell and captures f into
// table_out. Define SWEEP_CHECK_EN to add the expected-table comparison ports.
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int DWELL = DEFAULT_DWELL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         a,
    output logic         b,
    output logic         c,
    output logic         d,
    input  logic         f,
    output logic         busy,
    output logic         done,
    output logic [15:0]  table_out,
    output sweep_state_t state
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [15:0]  expected,
    output logic         mismatch,
    output logic [4:0]   err_count
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(N_VEC - 1);

    sweep_state_t state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [15:0]  table_q, table_d;
    logic         cnt_clear, cnt_en, sample;
    logic         accept, finish;

    truth_table_sweep_dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .en   (cnt_en),
        .tc   (sample)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        table_d   = table_q;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_APPLY;
                    idx_d   = 4'd0;
                    table_d = 16'h0000;
                end
            end
            ST_APPLY: begin
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (sample) begin
                    table_d[idx_q] = f;
                    if (idx_q == LAST_IDX) begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            table_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
        end
    end

    // Stimulus is only driven while applying; IDLE and DONE present zero.
    assign {a, b, c, d} = (state_q == ST_APPLY) ? idx_q : 4'd0;
    assign busy         = (state_q == ST_APPLY);
    assign done         = (state_q == ST_DONE);
    assign table_out    = table_q;
    assign state        = state_q;

`ifdef SWEEP_CHECK_EN
    logic [4:0] diff_bits;
    assign diff_bits = popcount16(table_d ^ expected);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_count <= 5'd0;
            mismatch  <= 1'b0;
        end else if (finish) begin
            err_count <= diff_bits;
            mismatch  <= (diff_bits != 5'd0);
        end
    end
`else
    logic unused_flags;
    assign unused_flags = accept ^ finish;
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep: two instances (DWELL 20 and 1),
// directed sweeps with hand-computed tables, monitors compare on done.
module tb_truth_table_sweep;
    import truth_table_sweep_pkg::*;

    localparam int SLOW_DW = 20;
    localparam int FAST_DW = 1;
    localparam int SLOW_LAT = 16 * SLOW_DW + 1;
    localparam int FAST_LAT = 16 * FAST_DW + 1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         start_s = 1'b0, start_f = 1'b0;
    logic         a_s, b_s, c_s, d_s, a_f, b_f, c_f, d_f;
    logic         f_s, f_f;
    logic         busy_s, busy_f, done_s, done_f;
    logic [15:0]  table_s, table_f;
    sweep_state_t state_s, state_f;
    logic [1:0]   mode_s = 2'd0, mode_f = 2'd0;
    logic [15:0]  expected_s = 16'h0000;
`ifdef SWEEP_CHECK_EN
    logic         mismatch_s, mismatch_f;
    logic [4:0]   err_count_s, err_count_f;
`endif

    // mode 0: a&b, 1: a^b^c^d, 2: ~d, 3: d
    function automatic logic fsel(input logic [1:0] m, input logic [3:0] v);
        case (m)
            2'd0:    return v[3] & v[2];
            2'd1:    return ^v;
            2'd2:    return ~v[0];
            default: return v[0];
        endcase
    endfunction

    always_comb f_s = fsel(mode_s, {a_s, b_s, c_s, d_s});
    always_comb f_f = fsel(mode_f, {a_f, b_f, c_f, d_f});

    truth_table_sweep #(.DWELL(SLOW_DW)) u_slow (
        .clk(clk), .rst(rst), .start(start_s),
        .a(a_s), .b(b_s), .c(c_s), .d(d_s), .f(f_s),
        .busy(busy_s), .done(done_s), .table_out(table_s), .state(state_s)
`ifdef SWEEP_CHECK_EN
        , .expected(expected_s), .mismatch(mismatch_s), .err_count(err_count_s)
`endif
    );

    truth_table_sweep #(.DWELL(FAST_DW)) u_fast (
        .clk(clk), .rst(rst), .start(start_f),
        .a(a_f), .b(b_f), .c(c_f), .d(d_f), .f(f_f),
        .busy(busy_f), .done(done_f), .table_out(table_f), .state(state_f)
`ifdef SWEEP_CHECK_EN
        , .expected(16'h0000), .mismatch(mismatch_f), .err_count(err_count_f)
`endif
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_tbl_s[$], exp_tbl_f[$];
    int unsigned exp_cyc_s[$], exp_cyc_f[$];
    logic [4:0]  exp_err_s[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        $display("FAIL %s: %s", name, why);
    endtask

    always @(negedge clk) begin
        if (done_s) begin
            if (exp_tbl_s.size() == 0) begin
                fail_now("done_slow", "got unexpected done pulse, expected none");
            end else begin
                logic [15:0] et;
                int unsigned ec;
                logic [4:0]  ee;
                et = exp_tbl_s.pop_front();
                ec = exp_cyc_s.pop_front();
                ee = exp_err_s.pop_front();
                chk("table_slow", {16'd0, table_s}, {16'd0, et});
                chk("latency_slow", cyc, ec);
                chk("busy_at_done_slow", {31'd0, busy_s}, 32'd0);
`ifdef SWEEP_CHECK_EN
                chk("err_count_slow", {27'd0, err_count_s}, {27'd0, ee});
                chk("mismatch_slow", {31'd0, mismatch_s}, {31'd0, (ee != 5'd0)});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done_f) begin
            if (exp_tbl_f.size() == 0) begin
                fail_now("done_fast", "got unexpected done pulse, expected none");
            end else begin
                logic [15:0] et;
                int unsigned ec;
                et = exp_tbl_f.pop_front();
                ec = exp_cyc_f.pop_front();
                chk("table_fast", {16'd0, table_f}, {16'd0, et});
                chk("latency_fast", cyc, ec);
                chk("busy_at_done_fast", {31'd0, busy_f}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_sweep(input bit fast, input logic [1:0] m, input logic [15:0] tbl,
                               input logic [15:0] expv, input logic [4:0] errv);
        @(negedge clk);
        if (fast) begin
            mode_f = m;
            exp_tbl_f.push_back(tbl);
            exp_cyc_f.push_back(cyc + FAST_LAT);
            start_f = 1'b1;
        end else begin
            mode_s     = m;
            expected_s = expv;
            exp_tbl_s.push_back(tbl);
            exp_cyc_s.push_back(cyc + SLOW_LAT);
            exp_err_s.push_back(errv);
            start_s = 1'b1;
        end
        @(negedge clk);
        start_s = 1'b0;
        start_f = 1'b0;
    endtask

    task automatic wait_done(input bit fast, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = fast ? done_f : done_s;
        end
        if (!seen) fail_now(name, $sformatf("got no done, expected one within %0d cycles", budget));
    endtask

    task automatic wait_vector(input bit fast, input logic [3:0] v, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            seen = fast ? ({a_f, b_f, c_f, d_f} == v) : ({a_s, b_s, c_s, d_s} == v);
            if (!seen) @(negedge clk);
        end
        if (!seen) fail_now(name, $sformatf("got no vector %0d, expected it within %0d cycles", v, budget));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_table_slow", {16'd0, table_s}, 32'd0);
        chk("rst_abcd_slow", {28'd0, a_s, b_s, c_s, d_s}, 32'd0);
        chk("rst_busy_slow", {31'd0, busy_s}, 32'd0);
        chk("rst_done_slow", {31'd0, done_s}, 32'd0);
        chk("rst_state_slow", {30'd0, state_s}, {30'd0, ST_IDLE});
        chk("rst_table_fast", {16'd0, table_f}, 32'd0);
        chk("rst_busy_fast", {31'd0, busy_f}, 32'd0);
        rst = 1'b0;

        // f = a&b, DWELL 20; expected differs in bit 0 only
        start_sweep(1'b0, 2'd0, 16'hF000, 16'hF001, 5'd1);
        chk("busy_after_start_slow", {31'd0, busy_s}, 32'd1);
        wait_done(1'b0, SLOW_LAT + 20, "sweep1_slow");
        repeat (2) @(negedge clk);
        chk("busy_after_done_slow", {31'd0, busy_s}, 32'd0);
        chk("hold_table_slow", {16'd0, table_s}, 32'h0000F000);

        // f = a^b^c^d, DWELL 1
        start_sweep(1'b1, 2'd1, 16'h6996, 16'h0000, 5'd0);
        wait_done(1'b1, FAST_LAT + 20, "xor_fast");

        // start re-asserted mid-sweep is ignored
        start_sweep(1'b0, 2'd0, 16'hF000, 16'hF000, 5'd0);
        wait_vector(1'b0, 4'd7, 8 * SLOW_DW + 20, "reach_idx7_slow");
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("busy_during_restart_slow", {31'd0, busy_s}, 32'd1);
        wait_done(1'b0, SLOW_LAT, "restart_slow");
        repeat (SLOW_DW) @(negedge clk);

        // reset at index 5 discards the partial table
        start_sweep(1'b1, 2'd1, 16'h6996, 16'h0000, 5'd0);
        wait_vector(1'b1, 4'd5, 40, "reach_idx5_fast");
        rst = 1'b1;
        exp_tbl_f.delete();
        exp_cyc_f.delete();
        @(negedge clk);
        chk("midrst_table_fast", {16'd0, table_f}, 32'd0);
        chk("midrst_abcd_fast", {28'd0, a_f, b_f, c_f, d_f}, 32'd0);
        chk("midrst_busy_fast", {31'd0, busy_f}, 32'd0);
        chk("midrst_done_fast", {31'd0, done_f}, 32'd0);
        chk("midrst_state_fast", {30'd0, state_f}, {30'd0, ST_IDLE});
        rst = 1'b0;
        start_sweep(1'b1, 2'd1, 16'h6996, 16'h0000, 5'd0);
        wait_done(1'b1, FAST_LAT + 20, "after_rst_fast");

        // back to back: f = ~d then f = d
        start_sweep(1'b1, 2'd2, 16'h5555, 16'h0000, 5'd0);
        wait_done(1'b1, FAST_LAT + 20, "notd_fast");
        start_sweep(1'b1, 2'd3, 16'hAAAA, 16'h0000, 5'd0);
        chk("cleared_on_start_fast", {16'd0, table_f}, 32'd0);
        wait_done(1'b1, FAST_LAT + 20, "d_fast");

        repeat (10) @(negedge clk);
        chk("drained_slow", exp_tbl_s.size(), 32'd0);
        chk("drained_fast", exp_tbl_f.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
# truth_table_sweep

Sequential stimulus-and-capture stage that sits upstream of a 4-input combinational function under test. On a start pulse it drives all 16 input combinations {a,b,c,d}, holding each for a programmable dwell time, and samples the function's output f at the end of each dwell. It assembles the 16-entry truth table and signals completion, replacing hand-written per-vector delays with a clocked, repeatable sweep.

## Interface
- DWELL, 20, clock cycles each vector is held (must be ≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- a  output  1  stimulus bit 3 (MSB of vector index)
- b  output  1  stimulus bit 2
- c  output  1  stimulus bit 1
- d  output  1  stimulus bit 0 (LSB)
- f  input  1  response from the function under test
- busy  output  1  high from the cycle after start is accepted until the last sample is taken
- done  output  1  one-cycle pulse when the table is complete
- table_out  output  16  captured truth table; bit i = f sampled while {a,b,c,d} = i

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: a,b,c,d = 0, busy = 0. On start = 1: clear table_out, vector index = 0, dwell counter = 0, go to APPLY.
- APPLY: {a,b,c,d} = vector index; dwell counter increments each cycle. On the cycle the counter equals DWELL−1: table_out[index] <= f, counter <= 0. If index = 15 go to DONE, else index <= index+1 (stay in APPLY).
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE. table_out holds until the next accepted start or reset.
- start asserted in APPLY or DONE is ignored (no restart, no queueing).
- Index is 4 bits, no wrap: the sweep ends after index 15.
- Dwell counter width $clog2(DWELL+1); DWELL = 1 samples f in the same cycle the vector is first driven (valid for a combinational DUT).

## Timing
- Reset values: a=b=c=d=0, busy=0, done=0, table_out=16'h0000, state IDLE, index 0, counter 0.
- start sampled high at edge t → busy=1 and vector 0 on outputs after edge t.
- Vector i is driven for cycles [t+1+i·DWELL, t+(i+1)·DWELL]; f sampled at the last of those edges.
- done pulses in the cycle following edge t+16·DWELL; total sweep latency 16·DWELL+1 cycles from start.
- rst during any state: all state and outputs return to reset values on the next edge; a partial table is discarded.
- rst and start in the same cycle: reset wins, start is dropped.

## Configuration
- SWEEP_CHECK_EN defined: adds input expected[15:0] and outputs mismatch (1) and err_count (5). At the DONE transition, err_count = popcount(table_out ^ expected) and mismatch = (err_count ≠ 0). Both are cleared by reset and on accepted start.
- Not defined: these ports and their logic are absent; the remaining behaviour is identical.

## Structure
- Shared include header: state encodings (IDLE/APPLY/DONE), N_VEC = 16, and the default DWELL.
- One sub-module, dwell_counter: counts 0..DWELL−1, has a clear input, and produces a terminal-count pulse used as the sample strobe.

## Test plan
- f = a&b, DWELL=20, start pulse → table_out = 16'hF000, done pulse at exactly 321 cycles after start, busy low afterwards.
- f = a^b^c^d, DWELL=1 → table_out = 16'h6996, done 17 cycles after start.
- start re-asserted while index = 7 → ignored; the sweep completes normally with an unchanged table and a single done pulse.
- rst asserted while index = 5 → next cycle: all outputs at reset values; a new start then yields a full correct table.
- Two sweeps back to back with f = ~d, then f = d → first table 16'h5555, second 16'hAAAA, with the table cleared when the second start is accepted.
- SWEEP_CHECK_EN, f = a&b, expected = 16'hF001 → mismatch = 1, err_count = 1; with expected = 16'hF000 → mismatch = 0, err_count = 0.
